// File: rtl/sdram_arb.sv
// Two-client round-robin arbiter/sequencer in front of sdram_c: grants one burst at a
// time, issues a single wr_req/rd_req pulse, routes read beats back and flags stalls.
module sdram_arb #(
  parameter int TIMEOUT = 64,
  parameter int TW      = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        c0_req,
  input  logic        c0_wr,
  input  logic [22:0] c0_addr,
  input  logic [8:0]  c0_cnt,
  input  logic [47:0] c0_wdata,
  output logic        c0_gnt,
  output logic        c0_done,
  output logic [47:0] c0_rdata,
  output logic        c0_rvld,
  input  logic        c1_req,
  input  logic        c1_wr,
  input  logic [22:0] c1_addr,
  input  logic [8:0]  c1_cnt,
  input  logic [47:0] c1_wdata,
  output logic        c1_gnt,
  output logic        c1_done,
  output logic [47:0] c1_rdata,
  output logic        c1_rvld,
  output logic        wr_req,
  output logic        rd_req,
  output logic [22:0] wr_addr,
  output logic [8:0]  wr_cnt,
  output logic [47:0] wr_data,
  input  logic [47:0] rd_data,
  input  logic        rd_vld,
  input  logic        ctrl_busy,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RUN,
    S_DONE
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic        r_owner;
  logic        r_last;
  logic        r_wr;
  logic [22:0] r_addr;
  logic [8:0]  r_cnt;
  logic [TW-1:0] r_timer;
  logic [9:0]  r_beat;
  logic        r_tmo;

  logic        r_gnt0;
  logic        r_gnt1;
  logic        r_done0;
  logic        r_done1;
  logic        r_err;
  logic        r_rvld0;
  logic        r_rvld1;
  logic [47:0] r_rdata0;
  logic [47:0] r_rdata1;

  logic        w_any;
  logic        w_sel;
  logic        w_sel_wr;
  logic [22:0] w_sel_addr;
  logic [8:0]  w_sel_cnt;
  logic        w_tmo_hit;
  logic        w_rd_beat;
  logic        w_len_bad;

  // On a tie the client that was not served last wins; r_last resets to 1 so c0 wins first.
  assign w_any      = c0_req | c1_req;
  assign w_sel      = (c0_req & c1_req) ? ~r_last : c1_req;
  assign w_sel_wr   = w_sel ? c1_wr   : c0_wr;
  assign w_sel_addr = w_sel ? c1_addr : c0_addr;
  assign w_sel_cnt  = w_sel ? c1_cnt  : c0_cnt;

  assign w_tmo_hit  = (r_timer == TW'(TIMEOUT - 1));
  assign w_rd_beat  = (r_state == S_RUN) && rd_vld && !r_wr;
  assign w_len_bad  = !r_wr && (r_beat != {1'b0, r_cnt});

  always_comb begin
    // NOTE: assign a default before the case so every path drives w_next and no latch is inferred.
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_any) w_next = (w_sel_cnt == '0) ? S_DONE : S_ISSUE;
      S_ISSUE: w_next = S_WAIT;
      S_WAIT: begin
        if (ctrl_busy)      w_next = S_RUN;
        else if (w_tmo_hit) w_next = S_DONE;
      end
      S_RUN:   if (!ctrl_busy) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner  <= 1'b0;
      r_last   <= 1'b1;
      r_wr     <= 1'b0;
      r_addr   <= '0;
      r_cnt    <= '0;
      r_timer  <= '0;
      r_beat   <= '0;
      r_tmo    <= 1'b0;
      r_gnt0   <= 1'b0;
      r_gnt1   <= 1'b0;
      r_done0  <= 1'b0;
      r_done1  <= 1'b0;
      r_err    <= 1'b0;
      r_rvld0  <= 1'b0;
      r_rvld1  <= 1'b0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else begin
      r_gnt0  <= 1'b0;
      r_gnt1  <= 1'b0;
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
      r_err   <= 1'b0;
      r_rvld0 <= 1'b0;
      r_rvld1 <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_owner <= w_sel;
            r_wr    <= w_sel_wr;
            r_addr  <= w_sel_addr;
            r_cnt   <= w_sel_cnt;
            r_gnt0  <= ~w_sel;
            r_gnt1  <= w_sel;
          end
        end
        S_ISSUE: begin
          r_timer <= '0;
          r_tmo   <= 1'b0;
        end
        S_WAIT: begin
          r_timer <= r_timer + TW'(1);
          if (!ctrl_busy && w_tmo_hit) r_tmo <= 1'b1;
        end
        S_RUN: begin
          // Read beats reach only the owner; stray or write-phase rd_vld never gets here.
          if (w_rd_beat) begin
            r_beat <= r_beat + 10'd1;
            if (r_owner) begin
              r_rdata1 <= rd_data;
              r_rvld1  <= 1'b1;
            end else begin
              r_rdata0 <= rd_data;
              r_rvld0  <= 1'b1;
            end
          end
        end
        S_DONE: begin
          r_done0 <= ~r_owner;
          r_done1 <= r_owner;
          r_err   <= r_tmo | w_len_bad;
          r_last  <= r_owner;
          r_beat  <= '0;
          r_tmo   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign c0_gnt   = r_gnt0;
  assign c1_gnt   = r_gnt1;
  assign c0_done  = r_done0;
  assign c1_done  = r_done1;
  assign err      = r_err;
  assign c0_rvld  = r_rvld0;
  assign c1_rvld  = r_rvld1;
  assign c0_rdata = r_rdata0;
  assign c1_rdata = r_rdata1;

  assign wr_req   = (r_state == S_ISSUE) &&  r_wr;
  assign rd_req   = (r_state == S_ISSUE) && !r_wr;
  assign wr_addr  = (r_state == S_IDLE) ? '0 : r_addr;
  assign wr_cnt   = (r_state == S_IDLE) ? '0 : r_cnt;
  assign wr_data  = r_owner ? c1_wdata : c0_wdata;

endmodule

// File: doc/sdram_arb.md
Name: sdram_arb

Overview:
Two-client round-robin arbiter and sequencer placed in front of the sdram_c controller. Each client submits complete burst transactions (read or write, address, length). The arbiter grants one client at a time and issues a single wr_req/rd_req pulse to sdram_c. It holds the command fields stable until the controller finishes, then routes read data back to the owning client. It also detects a stalled controller and read-length mismatches.

Parameters:
TIMEOUT, 64, max cycles in WAIT for ctrl_busy to rise before aborting
TW, 7, width of timeout counter (must hold TIMEOUT)

Ports:
clk  in  1  system clock, 100 MHz, shared with sdram_c
rst_n  in  1  asynchronous active-low reset
c0_req  in  1  client 0 transaction request, level
c0_wr  in  1  client 0 direction, 1=write 0=read
c0_addr  in  23  client 0 start address {bank[22:21], row[20:9], col[8:0]} in sdram_c format
c0_cnt  in  9  client 0 burst length in words
c0_wdata  in  48  client 0 write data, driven by client per beat
c0_gnt  out  1  client 0 grant, 1-cycle pulse
c0_done  out  1  client 0 transaction complete, 1-cycle pulse
c0_rdata  out  48  client 0 read data
c0_rvld  out  1  client 0 read data valid
c1_req, c1_wr, c1_addr, c1_cnt, c1_wdata, c1_gnt, c1_done, c1_rdata, c1_rvld: same as c0_*, for client 1
wr_req  out  1  to sdram_c, write command pulse
rd_req  out  1  to sdram_c, read command pulse
wr_addr  out  23  to sdram_c, transaction address
wr_cnt  out  9  to sdram_c, transaction length
wr_data  out  48  to sdram_c, owner's cN_wdata (combinational mux)
rd_data  in  48  from sdram_c
rd_vld  in  1  from sdram_c
ctrl_busy  in  1  from sdram_c, high while a command burst executes
err  out  1  error pulse, coincident with the offending cN_done

Behaviour:
- Reset (async, any time, including mid-burst): state IDLE; all outputs 0; wr_addr/wr_cnt 0; owner 0; last-served pointer 1, so client 0 wins the first tie; beat and timeout counters 0. An in-flight transaction is abandoned with no done pulse.
- States: IDLE, ISSUE, WAIT, RUN, DONE.
- IDLE: if a cN_req is high, select the client. If both are high, select the client other than last-served. In the same edge:
  - latch that client's wr/addr/cnt into internal registers;
  - pulse cN_gnt for 1 cycle;
  - set owner.
  Next state is ISSUE, or DONE if latched cnt == 0 (no command issued, no err).
- Clients hold req and fields until gnt. A req still high in the cycle after done is a new request.
- ISSUE: for exactly 1 cycle, wr_req=1 if latched wr, else rd_req=1. wr_addr/wr_cnt drive latched values from ISSUE until DONE exit. Clear timer. Go to WAIT.
- WAIT: increment timer each cycle.
  - ctrl_busy=1 → RUN.
  - Timer reaches TIMEOUT-1 with no busy → DONE with err flagged.
- RUN: for a read owned by client N, each rd_vld registers to cN_rvld/cN_rdata with 1-cycle latency and increments the beat counter. The other client's rvld stays 0. ctrl_busy falling → DONE.
- DONE: 1 cycle.
  - Pulse cN_done for the owner.
  - Pulse err if timeout occurred, or if a read ended with beat count != latched cnt.
  - Update last-served to owner; clear beat counter; go to IDLE.
  - Next grant is possible at the earliest 1 cycle after DONE.
- rd_vld while not in RUN, or during a write, is dropped. It does not count and is not forwarded.
- wr_data = owner ? c1_wdata : c0_wdata at all times. Clients must present each beat's data per sdram_c write timing while owning the bus.
- cN_rdata holds its last value when rvld is 0. Reset value is 0.
- Guarantee: at most one of wr_req/rd_req is high, and only in ISSUE. gnt and done never pulse for both clients in the same cycle.

Test Plan:
- Single read: c0 read, addr 23'h40_0501, cnt 5; model asserts busy 3 cycles after rd_req and gives 5 rd_vld beats (data 10..14) → one c0_gnt, one rd_req pulse, c0_rvld 5 beats with data 10..14 one cycle after each rd_vld, c0_done once, err=0, c1_rvld never high.
- Simultaneous requests: c0 and c1 both request from reset, both re-request after done → grant order c0, c1, c0, c1; no overlapping transactions.
- Write path: c1 write, cnt 4, c1_wdata changing per beat → wr_req pulse with wr_cnt=4 and latched address; wr_data follows c1_wdata; c1_done after busy falls; rd_req stays 0.
- Timeout: c0 read with busy never asserted → c0_done and err pulse together exactly TIMEOUT+2 cycles after c0_gnt; arbiter returns to IDLE and serves c1 next.
- Edge cases: cnt=0 request → gnt then done, no wr_req/rd_req. Read with 3 rd_vld for cnt=5 → err with done. Stray rd_vld in IDLE → ignored.
- Reset mid-RUN after 2 of 5 beats → all outputs 0 immediately; no done pulse; a fresh c1 request after reset completes normally.
